// File: rtl/cj_merge_arb_if.sv
// Handshake bundle between two requesters, the merge arbiter and its stage.
// slave = arbiter side, master = requesters/downstream environment side.
interface cj_merge_arb_if #(
  parameter int DATA_W = 8
);
  logic              Send_in0;
  logic [DATA_W-1:0] Data_in0;
  logic              Ack_out0;
  logic              Send_in1;
  logic [DATA_W-1:0] Data_in1;
  logic              Ack_out1;
  logic              Send_out;
  logic [DATA_W-1:0] Data_out;
  logic              Ack_in;
  logic              Ga;
  logic              CP;
  logic [1:0]        Grant;
  logic              Busy;
  logic              Err;

  modport slave (
    input  Send_in0, Data_in0, Send_in1, Data_in1,
    input  Ack_in, Ga,
    output Ack_out0, Ack_out1, Send_out, Data_out,
    output CP, Grant, Busy, Err
  );

  modport master (
    output Send_in0, Data_in0, Send_in1, Data_in1,
    output Ack_in, Ga,
    input  Ack_out0, Ack_out1, Send_out, Data_out,
    input  CP, Grant, Busy, Err
  );
endinterface

// File: rtl/cj_merge_arb.sv
// Round-robin two-requester merge arbiter for a four-phase Send/Ack stage.
// Ports: CLK, MR (sync active-high reset), bus (slave side of the bundle).
module cj_merge_arb #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input logic          CLK,
  input logic          MR,
  cj_merge_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              cp_q, cp_d;
  logic              last_q, last_d;
  logic              pick1;
  logic              own_send;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    cp_d     = 1'b0;
    last_d   = last_q;
    // On a tie port 1 wins only if port 0 was served last
    pick1    = bus.Send_in1 & (~bus.Send_in0 | ~last_q);
    own_send = grant_q[1] ? bus.Send_in1 : bus.Send_in0;
    unique case (state_q)
      IDLE: begin
        if (bus.Ga && !bus.Ack_in &&
            (bus.Send_in0 || bus.Send_in1)) begin
          state_d = REQ;
          cnt_d   = '0;
          grant_d = pick1 ? 2'b10 : 2'b01;
          data_d  = pick1 ? bus.Data_in1 : bus.Data_in0;
        end
      end
      REQ: begin
        if (bus.Ack_in) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q != TO_MAX) begin
          cnt_d = cnt_q + TO_W'(1);
          if (cnt_d == TO_MAX) err_d = 1'b1;
        end
      end
      REL: begin
        if (!own_send && !bus.Ack_in) begin
          state_d = IDLE;
          cp_d    = 1'b1;
          last_d  = grant_q[1];
          grant_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      cp_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      cp_q    <= cp_d;
      last_q  <= last_d;
    end
  end

  assign bus.Send_out = (state_q == REQ);
  assign bus.Ack_out0 = (state_q == REL) & grant_q[0];
  assign bus.Ack_out1 = (state_q == REL) & grant_q[1];
  assign bus.Data_out = data_q;
  assign bus.CP       = cp_q;
  assign bus.Grant    = grant_q;
  assign bus.Busy     = (state_q != IDLE);
  assign bus.Err      = err_q;

endmodule

// File: tb/tb_cj_merge_arb.sv
// Directed bench for cj_merge_arb: reset, single, round-robin, gate,
// timeout, release ordering and reset during release.
module tb_cj_merge_arb;

  logic CLK;
  logic MR;
  int   n_chk  = 0;
  int   n_pass = 0;

  cj_merge_arb_if #(.DATA_W(8)) bus ();

  cj_merge_arb #(
    .DATA_W (8),
    .TIMEOUT(255),
    .TO_W   (8)
  ) dut (
    .CLK(CLK),
    .MR (MR),
    .bus(bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] all_out();
    return 32'({bus.Send_out, bus.Ack_out0, bus.Ack_out1, bus.CP,
                bus.Grant, bus.Busy, bus.Err, bus.Data_out});
  endfunction

  initial begin
    int          got_n;
    int          both_bad;
    int          gate_bad;
    int          rel_bad;
    logic [1:0]  gprev;
    logic [7:0]  got_d [4];
    logic [1:0]  got_g [4];

    MR = 1'b1;
    bus.Send_in0 = 1'b0;
    bus.Send_in1 = 1'b0;
    bus.Data_in0 = 8'h00;
    bus.Data_in1 = 8'h00;
    bus.Ack_in   = 1'b0;
    bus.Ga       = 1'b1;
    repeat (2) step();
    chk("reset_outputs", all_out(), 32'h0);
    MR = 1'b0;

    // single transfer from port 0
    bus.Send_in0 = 1'b1;
    bus.Data_in0 = 8'hA5;
    step();
    chk("single_send", 32'(bus.Send_out), 1);
    chk("single_data", 32'(bus.Data_out), 32'hA5);
    chk("single_grant", 32'(bus.Grant), 1);
    chk("single_busy", 32'(bus.Busy), 1);
    bus.Data_in0 = 8'h5A;
    step();
    step();
    chk("single_data_held", 32'(bus.Data_out), 32'hA5);
    chk("single_send_wait", 32'(bus.Send_out), 1);
    bus.Ack_in = 1'b1;
    step();
    chk("single_rel", 32'({bus.Send_out, bus.Ack_out0, bus.Ack_out1}),
        32'b010);
    bus.Send_in0 = 1'b0;
    bus.Ack_in   = 1'b0;
    step();
    chk("single_cp", 32'({bus.Ack_out0, bus.CP, bus.Grant, bus.Busy}),
        32'b01000);
    step();
    chk("single_cp_once", 32'(bus.CP), 0);

    // round robin with both requesters always asking
    MR = 1'b1;
    step();
    MR = 1'b0;
    bus.Data_in0 = 8'h11;
    bus.Data_in1 = 8'h22;
    bus.Send_in0 = 1'b1;
    bus.Send_in1 = 1'b1;
    got_n    = 0;
    both_bad = 0;
    gprev    = 2'b00;
    for (int cyc = 0; cyc < 100 && got_n < 4; cyc++) begin
      step();
      if (bus.Ack_out0 && bus.Ack_out1) both_bad++;
      if (bus.Send_out && (bus.Ack_out0 || bus.Ack_out1)) both_bad++;
      if (gprev == 2'b00 && bus.Grant != 2'b00) begin
        got_d[got_n] = bus.Data_out;
        got_g[got_n] = bus.Grant;
        got_n++;
      end
      gprev = bus.Grant;
      bus.Ack_in   = bus.Send_out;
      bus.Send_in0 = !bus.Ack_out0;
      bus.Send_in1 = !bus.Ack_out1;
    end
    chk("rr_count", 32'(got_n), 4);
    chk("rr_data", 32'({got_d[0], got_d[1], got_d[2], got_d[3]}),
        32'h11221122);
    chk("rr_grant", 32'({got_g[0], got_g[1], got_g[2], got_g[3]}),
        32'b01100110);
    chk("rr_exclusive", 32'(both_bad), 0);
    bus.Send_in0 = 1'b0;
    bus.Ack_in   = 1'b1;
    step();
    bus.Send_in1 = 1'b0;
    bus.Ack_in   = 1'b0;
    step();
    chk("rr_last_cp", 32'(bus.CP), 1);

    // gate holds off grants but not an in-flight transfer
    bus.Ga       = 1'b0;
    bus.Send_in1 = 1'b1;
    bus.Data_in1 = 8'h66;
    gate_bad     = 0;
    repeat (10) begin
      step();
      if (bus.Send_out || bus.Busy) gate_bad++;
    end
    chk("gate_hold", 32'(gate_bad), 0);
    bus.Ga = 1'b1;
    step();
    chk("gate_grant", 32'({bus.Grant, bus.Send_out, bus.Data_out}),
        32'({2'b10, 1'b1, 8'h66}));
    bus.Ga     = 1'b0;
    bus.Ack_in = 1'b1;
    step();
    chk("gate_ack1", 32'(bus.Ack_out1), 1);
    bus.Send_in1 = 1'b0;
    bus.Ack_in   = 1'b0;
    step();
    chk("gate_cp", 32'(bus.CP), 1);
    bus.Ga = 1'b1;

    // timeout sets sticky Err while request keeps waiting
    bus.Send_in0 = 1'b1;
    bus.Data_in0 = 8'h3C;
    step();
    chk("to_send", 32'(bus.Send_out), 1);
    repeat (254) step();
    chk("to_err_before", 32'(bus.Err), 0);
    step();
    chk("to_err_set", 32'(bus.Err), 1);
    repeat (44) step();
    chk("to_still_req", 32'({bus.Send_out, bus.Err}), 32'b11);
    bus.Ack_in = 1'b1;
    step();
    chk("to_ack0", 32'(bus.Ack_out0), 1);
    bus.Send_in0 = 1'b0;
    bus.Ack_in   = 1'b0;
    step();
    chk("to_cp_err", 32'({bus.CP, bus.Err}), 32'b11);

    // release: Ack_in drops 3 cycles before Send_in0
    bus.Send_in0 = 1'b1;
    bus.Data_in0 = 8'h44;
    step();
    bus.Ack_in = 1'b1;
    step();
    bus.Ack_in = 1'b0;
    rel_bad    = 0;
    repeat (3) begin
      step();
      if (!bus.Ack_out0 || bus.CP) rel_bad++;
    end
    chk("relA_hold", 32'(rel_bad), 0);
    bus.Send_in0 = 1'b0;
    step();
    chk("relA_done", 32'({bus.Ack_out0, bus.CP}), 32'b01);

    // release: Send_in0 drops 3 cycles before Ack_in
    bus.Send_in0 = 1'b1;
    step();
    bus.Ack_in = 1'b1;
    step();
    bus.Send_in0 = 1'b0;
    rel_bad      = 0;
    repeat (3) begin
      step();
      if (!bus.Ack_out0 || bus.CP) rel_bad++;
    end
    chk("relB_hold", 32'(rel_bad), 0);
    bus.Ack_in = 1'b0;
    step();
    chk("relB_done", 32'({bus.Ack_out0, bus.CP, bus.Err}), 32'b011);

    // reset while in release
    bus.Send_in1 = 1'b1;
    bus.Data_in1 = 8'h99;
    step();
    bus.Ack_in = 1'b1;
    step();
    chk("mr_in_rel", 32'(bus.Ack_out1), 1);
    MR           = 1'b1;
    bus.Send_in1 = 1'b0;
    bus.Ack_in   = 1'b0;
    step();
    chk("mr_outputs", all_out(), 32'h0);
    MR = 1'b0;
    step();
    chk("mr_no_cp", 32'(bus.CP), 0);
    bus.Data_in0 = 8'h77;
    bus.Data_in1 = 8'h88;
    bus.Send_in0 = 1'b1;
    bus.Send_in1 = 1'b1;
    step();
    chk("mr_tie_port0", 32'({bus.Grant, bus.Data_out}),
        32'({2'b01, 8'h77}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
